// File: rtl/slot_config_master_if.sv
// slot_config_master_if: host command byte stream and read-response byte stream
interface slot_config_master_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  modport master (input cmd_data, cmd_valid, rsp_ready, output cmd_ready, rsp_data, rsp_valid);
  modport slave (output cmd_data, cmd_valid, rsp_ready, input cmd_ready, rsp_data, rsp_valid);
endinterface

// File: rtl/slot_config_master.sv
// slot_config_master: command-driven master for the shared slot config bus.
// Optional write readback/compare is enabled by defining CFG_WRITE_VERIFY_EN.
module slot_config_master #(
  parameter int NUM_SLOTS = 4,
  parameter int READ_WAIT = 2
) (
  input  logic                 config_clk,
  input  logic                 reset,
  slot_config_master_if.master host,
  output logic [NUM_SLOTS-1:0] config_write,
  output logic [NUM_SLOTS-1:0] config_read,
  output logic [1:0]           config_addr,
  inout  wire  [7:0]           config_data,
  output logic                 busy,
  output logic                 err_slot
`ifdef CFG_WRITE_VERIFY_EN
  , output logic               verify_err
`endif
);
  typedef enum logic [2:0] {IDLE, WDATA, WRITE, WHOLD, READ, RESP
`ifdef CFG_WRITE_VERIFY_EN
    , VREAD
`endif
  } state_t;
  state_t state, state_n;
  logic [2:0] slot, slot_n;
  logic ok, ok_n, drive, drive_n, rsp_valid_n, err_n;
  logic [7:0] wdata, wdata_n, rsp_data_n, cnt, cnt_n;
  logic [1:0] addr_n;
  logic [NUM_SLOTS-1:0] wr_n, rd_n;
`ifdef CFG_WRITE_VERIFY_EN
  logic verify_n;
`endif
  wire take = host.cmd_valid && host.cmd_ready;
  wire last = cnt == 8'(READ_WAIT - 1);
  // Out-of-range slots shift out of the vector, so invalid commands select nothing.
  wire [NUM_SLOTS-1:0] sel = NUM_SLOTS'(1) << slot;
  wire [NUM_SLOTS-1:0] hdr_sel = NUM_SLOTS'(1) << host.cmd_data[6:4];
  assign config_data = drive ? wdata : 8'bz;
  always_comb begin
    state_n = state;
    slot_n = slot;
    ok_n = ok;
    wdata_n = wdata;
    addr_n = config_addr;
    drive_n = drive;
    wr_n = '0;
    rd_n = config_read;
    rsp_data_n = host.rsp_data;
    rsp_valid_n = host.rsp_valid;
    err_n = err_slot;
    cnt_n = cnt;
`ifdef CFG_WRITE_VERIFY_EN
    verify_n = verify_err;
`endif
    case (state)
      IDLE: if (take) begin
        slot_n = host.cmd_data[6:4];
        ok_n = 32'(host.cmd_data[6:4]) < NUM_SLOTS;
        err_n = err_slot | !ok_n;
        addr_n = host.cmd_data[1:0];
        cnt_n = '0;
        state_n = host.cmd_data[7] ? READ : WDATA;
        rd_n = host.cmd_data[7] ? hdr_sel : '0;
      end
      WDATA: if (take) begin
        wdata_n = host.cmd_data;
        drive_n = 1'b1;
        wr_n = sel;
        state_n = WRITE;
      end
      WRITE: state_n = WHOLD;
      WHOLD: begin
        drive_n = 1'b0;
        state_n = IDLE;
`ifdef CFG_WRITE_VERIFY_EN
        if (ok) begin
          state_n = VREAD;
          rd_n = sel;
          cnt_n = '0;
        end
`endif
      end
      READ: if (last) begin
        rsp_data_n = ok ? config_data : 8'h00;
        rsp_valid_n = 1'b1;
        rd_n = '0;
        state_n = RESP;
      end else cnt_n = cnt + 8'd1;
      RESP: if (host.rsp_ready) begin
        rsp_valid_n = 1'b0;
        state_n = IDLE;
      end
`ifdef CFG_WRITE_VERIFY_EN
      VREAD: if (last) begin
        verify_n = verify_err | (config_data != wdata);
        rd_n = '0;
        state_n = IDLE;
      end else cnt_n = cnt + 8'd1;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge config_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      slot <= '0;
      ok <= 1'b0;
      wdata <= '0;
      drive <= 1'b0;
      cnt <= '0;
      config_addr <= '0;
      config_write <= '0;
      config_read <= '0;
      host.cmd_ready <= 1'b1;
      host.rsp_data <= '0;
      host.rsp_valid <= 1'b0;
      busy <= 1'b0;
      err_slot <= 1'b0;
`ifdef CFG_WRITE_VERIFY_EN
      verify_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      slot <= slot_n;
      ok <= ok_n;
      wdata <= wdata_n;
      drive <= drive_n;
      cnt <= cnt_n;
      config_addr <= addr_n;
      config_write <= wr_n;
      config_read <= rd_n;
      host.cmd_ready <= state_n == IDLE || state_n == WDATA;
      host.rsp_data <= rsp_data_n;
      host.rsp_valid <= rsp_valid_n;
      busy <= state_n != IDLE;
      err_slot <= err_n;
`ifdef CFG_WRITE_VERIFY_EN
      verify_err <= verify_n;
`endif
    end
endmodule

// File: tb/tb_slot_config_master.sv
// tb_slot_config_master: directed bench with a dummy slave register file and a response scoreboard.
module tb_slot_config_master;
  localparam int NS = 4;
  localparam int RW = 2;
  logic config_clk = 1'b0;
  logic reset = 1'b1;
  logic [NS-1:0] config_write, config_read;
  logic [1:0] config_addr;
  wire [7:0] config_data;
  logic busy, err_slot;
`ifdef CFG_WRITE_VERIFY_EN
  logic verify_err;
`endif
  slot_config_master_if h();
  slot_config_master #(.NUM_SLOTS(NS), .READ_WAIT(RW)) dut (
    .config_clk(config_clk), .reset(reset), .host(h.master),
    .config_write(config_write), .config_read(config_read), .config_addr(config_addr),
    .config_data(config_data), .busy(busy), .err_slot(err_slot)
`ifdef CFG_WRITE_VERIFY_EN
    , .verify_err(verify_err)
`endif
  );
  always #5 config_clk = ~config_clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb [$];
  logic [7:0] regs [NS][4];
  int wr_cnt [NS];
  int rd_cyc [NS];
  int rsp_cyc = 0;
  logic stuck0 = 1'b0;
  int rsel;
  always_comb begin
    rsel = 0;
    for (int i = 0; i < NS; i++) if (config_read[i]) rsel = i;
  end
  assign config_data = |config_read ? (regs[rsel][config_addr] & {7'h7f, !stuck0}) : 8'bz;
  initial for (int i = 0; i < NS; i++) begin wr_cnt[i] = 0; rd_cyc[i] = 0; end
  always @(posedge config_clk) begin
    for (int i = 0; i < NS; i++) begin
      if (reset) for (int a = 0; a < 4; a++) regs[i][a] <= 8'h00;
      else if (config_write[i]) begin
        regs[i][config_addr] <= config_data;
        wr_cnt[i] <= wr_cnt[i] + 1;
      end
      if (config_read[i]) rd_cyc[i] <= rd_cyc[i] + 1;
    end
    if (h.rsp_valid) rsp_cyc <= rsp_cyc + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge config_clk) if (!reset) check("strobe_excl", 32'($countones({config_write, config_read}) <= 1), 1);
  task automatic tick();
    @(posedge config_clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    h.cmd_data = b;
    h.cmd_valid = 1'b1;
    while (!h.cmd_ready && n < 100) begin tick(); n++; end
    check("cmd_ready_wait", 32'(h.cmd_ready), 1);
    tick();
    h.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("idle_wait", 32'(busy), 0);
  endtask
  task automatic get_rsp();
    int n = 0;
    logic [7:0] e;
    while (!h.rsp_valid && n < 100) begin tick(); n++; end
    check("rsp_valid", 32'(h.rsp_valid), 1);
    e = sb.size() > 0 ? sb.pop_front() : 8'hxx;
    check("rsp_data", 32'(h.rsp_data), 32'(e));
    h.rsp_ready = 1'b1;
    tick();
    h.rsp_ready = 1'b0;
    check("rsp_drop", 32'(h.rsp_valid), 0);
    check("rsp_ready_back", 32'(h.cmd_ready), 1);
  endtask
  initial begin
    int snap_w, snap_r, snap_rsp;
    h.cmd_data = 8'h00;
    h.cmd_valid = 1'b0;
    h.rsp_ready = 1'b0;
    repeat (2) tick();
    check("rst_cmd_ready", 32'(h.cmd_ready), 1);
    check("rst_rsp_valid", 32'(h.rsp_valid), 0);
    check("rst_rsp_data", 32'(h.rsp_data), 0);
    check("rst_write", 32'(config_write), 0);
    check("rst_read", 32'(config_read), 0);
    check("rst_addr", 32'(config_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_slot), 0);
    reset = 1'b0;
    tick();
    // write slot 0 addr 1 = A5
    send(8'h01);
    check("wdata_busy", 32'(busy), 1);
    check("wdata_ready", 32'(h.cmd_ready), 1);
    send(8'hA5);
    check("wr_strobe", 32'(config_write), 32'h1);
    check("wr_addr", 32'(config_addr), 1);
    check("wr_data", 32'(config_data), 32'hA5);
    check("wr_ready", 32'(h.cmd_ready), 0);
    tick();
    check("whold_strobe", 32'(config_write), 0);
    check("whold_data", 32'(config_data), 32'hA5);
    check("whold_addr", 32'(config_addr), 1);
    wait_idle();
    check("wr_cnt0", 32'(wr_cnt[0]), 1);
    // read slot 0 addr 1 with latency check
    sb.push_back(8'hA5);
    send(8'h81);
    check("rd_strobe", 32'(config_read), 32'h1);
    check("rd_addr", 32'(config_addr), 1);
    repeat (RW - 1) tick();
    check("rd_not_yet", 32'(h.rsp_valid), 0);
    tick();
    check("rd_latency", 32'(h.rsp_valid), 1);
    check("rd_released", 32'(config_read), 0);
    get_rsp();
    check("err_clean", 32'(err_slot), 0);
    // slot isolation
    send(8'h23);
    send(8'h3C);
    wait_idle();
    sb.push_back(8'h00);
    send(8'h93);
    check("iso_rd_strobe", 32'(config_read), 32'h2);
    get_rsp();
    check("iso_wr2", 32'(wr_cnt[2]), 1);
    check("iso_wr1", 32'(wr_cnt[1]), 0);
    check("iso_wr3", 32'(wr_cnt[3]), 0);
    check("iso_rd1", 32'(rd_cyc[1]), RW);
    // invalid slot
    snap_w = wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
    snap_r = rd_cyc[0] + rd_cyc[1] + rd_cyc[2] + rd_cyc[3];
    send(8'h52);
    check("bad_err_set", 32'(err_slot), 1);
    send(8'h77);
    check("bad_no_wr", 32'(config_write), 0);
    wait_idle();
    sb.push_back(8'h00);
    send(8'hD2);
    check("bad_no_rd", 32'(config_read), 0);
    get_rsp();
    check("bad_wr_total", 32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3]), 32'(snap_w));
    check("bad_rd_total", 32'(rd_cyc[0] + rd_cyc[1] + rd_cyc[2] + rd_cyc[3]), 32'(snap_r));
    check("bad_err_sticky", 32'(err_slot), 1);
    // response backpressure with next header waiting
    send(8'h30);
    send(8'h5A);
    wait_idle();
    sb.push_back(8'h5A);
    send(8'hB0);
    h.cmd_data = 8'h80;
    h.cmd_valid = 1'b1;
    repeat (RW) tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(h.rsp_valid), 1);
      check("bp_data", 32'(h.rsp_data), 32'h5A);
      check("bp_ready", 32'(h.cmd_ready), 0);
      tick();
    end
    check("bp_pop", 32'(h.rsp_data), 32'(sb.size() > 0 ? sb.pop_front() : 8'hxx));
    h.rsp_ready = 1'b1;
    tick();
    h.rsp_ready = 1'b0;
    check("bp_drop", 32'(h.rsp_valid), 0);
    check("bp_cmd_ready", 32'(h.cmd_ready), 1);
    sb.push_back(8'h00);
    tick();
    h.cmd_valid = 1'b0;
    check("bp_next_rd", 32'(config_read), 32'h1);
    check("bp_next_addr", 32'(config_addr), 0);
    get_rsp();
    // reset during READ
    send(8'h81);
    check("mid_rd", 32'(config_read), 32'h1);
    reset = 1'b1;
    #2;
    check("mid_rst_rd", 32'(config_read), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(h.cmd_ready), 1);
    check("mid_rst_err", 32'(err_slot), 0);
    tick();
    reset = 1'b0;
    tick();
    send(8'h01);
    send(8'hC3);
    wait_idle();
    sb.push_back(8'hC3);
    send(8'h81);
    get_rsp();
`ifdef CFG_WRITE_VERIFY_EN
    snap_rsp = rsp_cyc;
    snap_r = rd_cyc[0];
    send(8'h02);
    send(8'h11);
    tick();
    tick();
    check("vfy_busy", 32'(busy), 1);
    check("vfy_rd", 32'(config_read), 32'h1);
    wait_idle();
    check("vfy_good", 32'(verify_err), 0);
    check("vfy_rd_cyc", 32'(rd_cyc[0] - snap_r), RW);
    check("vfy_no_rsp", 32'(rsp_cyc - snap_rsp), 0);
    stuck0 = 1'b1;
    send(8'h01);
    send(8'h01);
    wait_idle();
    check("vfy_bad", 32'(verify_err), 1);
    check("vfy_no_rsp2", 32'(rsp_cyc - snap_rsp), 0);
    stuck0 = 1'b0;
`else
    snap_rsp = rsp_cyc;
    send(8'h02);
    send(8'h11);
    tick();
    tick();
    check("nv_done", 32'(busy), 0);
    check("nv_no_rsp", 32'(rsp_cyc - snap_rsp), 0);
`endif
    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/slot_config_master.md
Name: slot_config_master

Overview:
- Command-driven master for the shared slot configuration bus, clocked by config_clk.
- Accepts a byte stream of register commands from the host interface.
- Turns each command into a single write or read transaction on one selected slot's config port: per-slot write/read strobes, shared 2-bit address and shared bidirectional 8-bit data.
- Returns read data to the host on a byte response stream. It sits directly upstream of each converter module's config_clk/config_write/config_read/config_addr/config_data port.

Parameters:
- NUM_SLOTS, 4, number of slot config ports (1..8).
- READ_WAIT, 2, config_clk edges from config_read assertion to the edge that samples config_data (min 2).

Ports:
- config_clk  input  1  bus and logic clock.
- reset  input  1  asynchronous, active-high.
- cmd_data  input  8  command byte.
- cmd_valid  input  1  cmd_data valid.
- cmd_ready  output  1  block accepts cmd_data this cycle.
- rsp_data  output  8  read-response byte.
- rsp_valid  output  1  rsp_data valid.
- rsp_ready  input  1  host consumes rsp_data.
- config_write  output  NUM_SLOTS  per-slot write strobe.
- config_read  output  NUM_SLOTS  per-slot read enable (slave drives config_data while high).
- config_addr  output  2  shared register address.
- config_data  inout  8  shared data bus; master drives only in WRITE/WHOLD, else high-Z.
- busy  output  1  high in any state other than IDLE.
- err_slot  output  1  sticky: a command addressed a slot >= NUM_SLOTS.

Behaviour:
- Clock and reset: reset, asynchronous, active-high; clock config_clk. All outputs are registered; all state changes on posedge config_clk.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, config_write=0, config_read=0, config_addr=0, config_data=Z, busy=0, err_slot=0, state=IDLE.
- Command header byte: [7]=rw (1=read), [6:4]=slot, [3:2] ignored, [1:0]=addr. A write header is followed by one data byte.
- Transfer rule: a byte transfers on an edge where cmd_valid && cmd_ready.
- FSM IDLE: cmd_ready=1. A header transfer latches slot/addr/rw.
  - rw=0: go to WDATA.
  - rw=1: go to READ, with config_addr=addr and config_read[slot]=1 registered on that edge.
- FSM WDATA: cmd_ready=1. On the data transfer, latch the data and go to WRITE with config_addr, config_data drive and config_write[slot]=1.
- FSM WRITE: exactly one cycle. config_write[slot]=1, data driven. Then go to WHOLD.
- FSM WHOLD: one cycle. config_write=0, data still driven, address held. Then go to IDLE (bus released).
- FSM READ: config_read[slot]=1, master high-Z, address held, for READ_WAIT cycles. On the READ_WAIT-th edge after entry: capture config_data into rsp_data, deassert config_read, go to RESP.
- FSM RESP: rsp_valid=1 and rsp_data stable until rsp_ready is sampled high. On that edge: rsp_valid=0, go to IDLE.
- cmd_ready is 0 in WRITE, WHOLD, READ and RESP. Commands never overlap.
- Invalid slot (slot >= NUM_SLOTS): err_slot is set on the header edge.
  - Write: the data byte is still consumed, no strobe is asserted, and WRITE/WHOLD run with config_write=0.
  - Read: no strobe is asserted, rsp_data=8'h00 after READ_WAIT cycles.
  - err_slot is cleared only by reset.
- Strobe exclusivity: at most one bit of config_write|config_read is high in any cycle, and never both vectors at once.
- Reset mid-operation: outputs return to reset values immediately and asynchronously. config_data is released, and a partial command is discarded.
- rsp_ready high outside RESP: ignored.

Optional Feature:
- Macro: CFG_WRITE_VERIFY_EN.
- When defined, WHOLD is followed by a readback. The block runs READ on the same slot/addr for READ_WAIT cycles, then compares the sampled value with the written data.
  - Mismatch: sticky output verify_err (1 bit, reset 0) is set.
  - No response byte is produced; the FSM returns to IDLE.
  - busy stays high throughout the readback.
  - Invalid-slot writes skip the verify.
- When undefined, the verify_err port and the readback states are absent, and a write finishes at WHOLD -> IDLE.

Test Plan:
- Write then read: send 0x01,0xA5 (slot 0, addr 1, data A5), then 0x81 against a dummy_adc slave. Required: one config_write[0] pulse with addr=1 and data=A5; rsp_data=0xA5 READ_WAIT+1 edges after the read header; err_slot=0.
- Slot isolation: write 0x3C to slot 2 addr 3 (0x23,0x3C), then read slot 1 addr 3 (0x93). Required: rsp=0x00; only config_write[2] pulsed; config_read[1] only during the read.
- Invalid slot (NUM_SLOTS=4): send 0x52,0x77, then 0xD2. Required: no strobes asserted; rsp=0x00; err_slot=1 and stays 1.
- Response backpressure: hold rsp_ready=0 for 10 cycles after a read, with cmd_valid=1 carrying the next header. Required: rsp_valid and rsp_data stable; cmd_ready=0 until the edge after rsp_ready=1.
- Reset mid-read: assert reset while in READ. Required: config_read=0 and config_data=Z immediately; busy=0; the next command is executed normally.
- CFG_WRITE_VERIFY_EN: force the slave's bit 0 stuck at 0, then write 0x01. Required: readback occurs and verify_err=1. With a good slave, verify_err=0 and no rsp_valid pulse.
